// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for an 8-digit seven-segment decoder.
// It steps through digits 0..7 and holds each digit for CLK_DIV clocks.
// It shows the matching nibble of the displayed value on num.
// New values are double-buffered and committed only at the frame boundary.
// Optional leading-zero blanking is controlled by lz_en.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        single-cycle request to capture value_in
//   value_in    32-bit hex value; nibble k is shown on digit k
//   lz_en       1 = suppress leading zeros
//   num         nibble for the current digit
//   sel         current digit index
//   blank       1 = current digit is dark
//   pending     1 = a loaded value is waiting for commit
//   frame_start one-cycle pulse in the first cycle of sel==0 after a commit
//
// CLK_DIV must be >= 2, and 2**CNT_W must be >= CLK_DIV.

module seg_scan_ctrl #(
  parameter int CLK_DIV = 100000,
  parameter int CNT_W   = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value_in,
  input  logic        lz_en,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        blank,
  output logic        pending,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [3:0]       num_q, num_d;
  logic             blank_q, blank_d;
  logic             pending_q, pending_d;
  logic             frame_start_q, frame_start_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      pend_q, pend_d;

  logic             tick;
  logic             commit;
  logic [7:0]       nib_zero;
  logic [7:0]       lead_zero;

  assign tick   = (div_cnt_q == DIV_MAX);
  assign commit = tick && (sel_q == 3'd7);

  // Next-state logic. The outputs are derived from the next display value and
  // the next digit index, so num never lags the digit it belongs to.
  always_comb begin
    div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
    sel_d         = tick ? sel_q + 3'd1 : sel_q;
    disp_d        = disp_q;
    pend_d        = pend_q;
    pending_d     = pending_q;
    frame_start_d = commit;
    num_d         = num_q;
    blank_d       = blank_q;

    if (commit) begin
      // A load on the commit cycle bypasses the pending buffer.
      if (load) begin
        disp_d = value_in;
      end else if (pending_q) begin
        disp_d = pend_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pend_d    = value_in;
      pending_d = 1'b1;
    end

    // lead_zero[k] is set when nibble k and every higher nibble are zero.
    for (int i = 0; i < 8; i++) begin
      nib_zero[i] = (disp_d[4*i +: 4] == 4'h0);
    end
    lead_zero[7] = nib_zero[7];
    for (int i = 6; i >= 0; i--) begin
      lead_zero[i] = nib_zero[i] & lead_zero[i+1];
    end

    // Between ticks num and blank hold. A change on lz_en waits for the next tick.
    if (tick) begin
      num_d   = disp_d[{sel_d, 2'b00} +: 4];
      blank_d = lz_en && (sel_d != 3'd0) && lead_zero[sel_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      sel_q         <= 3'd0;
      num_q         <= 4'h0;
      blank_q       <= 1'b0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      disp_q        <= 32'h0;
      pend_q        <= 32'h0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      sel_q         <= sel_d;
      num_q         <= num_d;
      blank_q       <= blank_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      disp_q        <= disp_d;
      pend_q        <= pend_d;
    end
  end

  assign num         = num_q;
  assign sel         = sel_q;
  assign blank       = blank_q;
  assign pending     = pending_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with CLK_DIV=4.
// A reference model tracks the number of clock edges since reset.
// The model derives the digit position from that edge count.
// It keeps the displayed and pending values as plain variables.
// Commits happen on every 32nd edge.

module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [31:0] value_in;
  logic        lz_en;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        blank;
  logic        pending;
  logic        frame_start;

  int total;
  int bad;

  // Reference model state.
  int          n_edges;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  logic        m_pending;
  logic        m_lz;

  seg_scan_ctrl #(.CLK_DIV(DIV), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value_in   (value_in),
    .lz_en      (lz_en),
    .num        (num),
    .sel        (sel),
    .blank      (blank),
    .pending    (pending),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cur_sel();
    return (n_edges / DIV) % 8;
  endfunction

  // A digit is dark if lz_en is set, it is not digit 0, and all digits from it upward are zero.
  function automatic logic exp_blank(input logic [31:0] v, input int s, input logic lz);
    if (!lz || s == 0) return 1'b0;
    for (int k = s; k < 8; k++) begin
      if (((v >> (4 * k)) & 32'hF) != 32'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n_edges);
    end
  endtask

  task automatic modelReset();
    n_edges   = 0;
    m_disp    = 32'h0;
    m_pend    = 32'h0;
    m_pending = 1'b0;
    m_lz      = 1'b0;
  endtask

  task automatic checkOutput();
    compare("sel", {29'h0, sel}, cur_sel());
    compare("num", {28'h0, num}, (m_disp >> (4 * cur_sel())) & 32'hF);
    compare("blank", {31'h0, blank}, {31'h0, exp_blank(m_disp, cur_sel(), m_lz)});
    compare("pending", {31'h0, pending}, {31'h0, m_pending});
    compare("frame_start", {31'h0, frame_start},
            {31'h0, (n_edges > 0 && n_edges % FRAME == 0)});
  endtask

  // Drive the inputs for one cycle, advance the model across the edge, then check.
  task automatic applyStimulus(input logic ld, input logic [31:0] val, input logic lz);
    load     = ld;
    value_in = val;
    lz_en    = lz;
    @(posedge clk);
    n_edges++;
    if (n_edges % FRAME == 0) begin
      m_disp    = ld ? val : (m_pending ? m_pend : m_disp);
      m_pending = 1'b0;
    end else if (ld) begin
      m_pend    = val;
      m_pending = 1'b1;
    end
    if (n_edges % DIV == 0) m_lz = lz;
    #1;
    load = 1'b0;
    checkOutput();
  endtask

  task automatic idle(input int cycles, input logic lz);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 32'h0, lz);
  endtask

  // Idle until the next edge would be sampled in the wanted digit slot.
  task automatic idleToSlot(input int s, input int cnt, input logic lz);
    for (int i = 0; i < FRAME && !(cur_sel() == s && n_edges % DIV == cnt); i++) begin
      applyStimulus(1'b0, 32'h0, lz);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value_in = 32'h0;
    lz_en    = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    compare("reset_sel", {29'h0, sel}, 32'h0);
    compare("reset_pending", {31'h0, pending}, 32'h0);
    rst_n = 1'b1;

    $display("[TB] idle scan after reset");
    idle(40, 1'b0);

    $display("[TB] load while sel=2");
    idleToSlot(2, 1, 1'b0);
    applyStimulus(1'b1, 32'h8765_4321, 1'b0);
    compare("pending_after_load", {31'h0, pending}, 32'h1);
    idle(FRAME + 8, 1'b0);

    $display("[TB] two loads before commit");
    idleToSlot(1, 0, 1'b0);
    applyStimulus(1'b1, 32'h1111_1111, 1'b0);
    idle(5, 1'b0);
    applyStimulus(1'b1, 32'hAAAA_5555, 1'b0);
    idle(FRAME + 4, 1'b0);

    $display("[TB] bypass load on commit cycle");
    idleToSlot(7, 3, 1'b0);
    applyStimulus(1'b1, 32'h0000_00C3, 1'b0);
    compare("bypass_num", {28'h0, num}, 32'h3);
    idle(DIV, 1'b0);
    compare("bypass_num_sel1", {28'h0, num}, 32'hC);
    idle(FRAME, 1'b0);

    $display("[TB] leading-zero blanking");
    applyStimulus(1'b1, 32'h0000_0A00, 1'b1);
    idle(2 * FRAME, 1'b1);
    applyStimulus(1'b1, 32'h0000_0000, 1'b1);
    idle(2 * FRAME, 1'b1);
    idle(FRAME, 1'b0);

    $display("[TB] reset mid-frame with pending value");
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
    idle(FRAME, 1'b0);
    idleToSlot(5, 1, 1'b0);
    applyStimulus(1'b1, 32'h1234_5678, 1'b0);
    rst_n = 1'b0;
    #1;
    compare("async_sel", {29'h0, sel}, 32'h0);
    compare("async_num", {28'h0, num}, 32'h0);
    compare("async_pending", {31'h0, pending}, 32'h0);
    compare("async_blank", {31'h0, blank}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    rst_n = 1'b1;
    idle(DIV - 1, 1'b0);
    compare("post_reset_sel_hold", {29'h0, sel}, 32'h0);
    idle(1, 1'b0);
    compare("post_reset_first_tick", {29'h0, sel}, 32'h1);
    idle(FRAME, 1'b0);

    $display("[TB] randomized loads and lz_en");
    begin
      logic lz_r;
      lz_r = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 19) == 0) lz_r = ~lz_r;
        applyStimulus(($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 1) == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom,
                      lz_r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
